slice_extract: RTL and testbench

SLICE_EXTRACT -- requirements
Module: slice_extract

---
 rtl/slice_extract_pkg.sv | 20 ++
 rtl/slice_extract_if.sv | 42 ++++
 rtl/slice_extract_slice_mux.sv | 36 +++
 rtl/slice_extract.sv | 141 ++++++++++++++
 tb/tb_slice_extract.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slice_extract_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slice_extract_pkg
// Description : Shared FSM state type and default geometry for the slice
//               extractor (vector width, slice width, slice index width).
// Revision    : 1.0 - initial release
// ============================================================================
package slice_extract_pkg;

    localparam int C_VEC_W   = 1536;
    localparam int C_SLICE_W = 24;
    localparam int C_IDX_W   = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/slice_extract_if.sv
`default_nettype none
// ============================================================================
// Module      : slice_extract_if
// Description : Bus bundle for the slice extractor: store load port, burst
//               request handshake and slice output handshake.
//   load/vec_in/load_err                   : store capture and rejection pulse
//   req_valid/req_ready/req_index/req_count: burst request
//   out_valid/out_ready/out_data/out_index/out_last : slice stream
//   master modport = requester/consumer side, slave modport = extractor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface slice_extract_if
    import slice_extract_pkg::*;
#(
    parameter int VEC_W   = C_VEC_W,
    parameter int SLICE_W = C_SLICE_W,
    parameter int IDX_W   = C_IDX_W
);
    logic               load;
    logic [VEC_W-1:0]   vec_in;
    logic               load_err;
    logic               req_valid;
    logic               req_ready;
    logic [IDX_W-1:0]   req_index;
    logic [IDX_W:0]     req_count;
    logic               out_valid;
    logic               out_ready;
    logic [SLICE_W-1:0] out_data;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;

    modport master (
        output load, vec_in, req_valid, req_index, req_count, out_ready,
        input  load_err, req_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  load, vec_in, req_valid, req_index, req_count, out_ready,
        output load_err, req_ready, out_valid, out_data, out_index, out_last
    );
endinterface
`default_nettype wire

// File: rtl/slice_extract_slice_mux.sv
`default_nettype none
// ============================================================================
// Module      : slice_mux
// Description : Combinational slice selector. Returns SLICE_W bits of the
//               store starting at index*SLICE_W+OFFSET, wrapping modulo VEC_W.
//   store_i : stored vector
//   index_i : slice index
//   slice_o : extracted slice
// Revision    : 1.0 - initial release
// ============================================================================
module slice_mux
    import slice_extract_pkg::*;
#(
    parameter int VEC_W   = C_VEC_W,
    parameter int SLICE_W = C_SLICE_W,
    parameter int IDX_W   = C_IDX_W,
    parameter int OFFSET  = 0
) (
    input  wire logic [VEC_W-1:0]   store_i,
    input  wire logic [IDX_W-1:0]   index_i,
    output logic      [SLICE_W-1:0] slice_o
);
    localparam int OFF_MOD = OFFSET % VEC_W;
    localparam int SH_W    = $clog2(2 * VEC_W);

    // Two copies back to back turn the modulo wrap into a plain part select:
    // base + OFF_MOD + SLICE_W - 1 always stays below 2*VEC_W.
    logic [2*VEC_W-1:0] w_dbl;
    logic [SH_W-1:0]    w_shift;

    assign w_dbl   = {store_i, store_i};
    assign w_shift = SH_W'(index_i) * SH_W'(SLICE_W) + SH_W'(OFF_MOD);
    assign slice_o = w_dbl[w_shift +: SLICE_W];

endmodule
`default_nettype wire

// File: rtl/slice_extract.sv
`default_nettype none
// ============================================================================
// Module      : slice_extract
// Description : Holds a VEC_W-bit vector and streams bursts of consecutive
//               SLICE_W-bit slices from it, with valid/ready backpressure.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slice_extract_if slave (load, request and output handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module slice_extract
    import slice_extract_pkg::*;
#(
    parameter int VEC_W   = C_VEC_W,
    parameter int SLICE_W = C_SLICE_W,
    parameter int IDX_W   = C_IDX_W,
    parameter int OFFSET  = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    slice_extract_if.slave     bus
);
    state_t             state_q, state_d;
    logic [VEC_W-1:0]   store_q, store_d;
    logic [IDX_W-1:0]   idx_q, idx_d;        // next index to emit
    logic [IDX_W:0]     rem_q, rem_d;        // slices still to emit
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [SLICE_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic               load_err_q, load_err_d;

    logic               w_idle_free;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_advance;
    logic [IDX_W-1:0]   w_mux_idx;
    logic [IDX_W:0]     w_req_total;
    logic [SLICE_W-1:0] w_slice;

    assign w_idle_free = (state_q == IDLE) && !out_valid_q;
    assign w_req_ready = w_idle_free && !bus.load;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_advance   = !out_valid_q || bus.out_ready;
    // The first slice of a burst is read straight from the request so it can
    // appear the cycle after acceptance.
    assign w_mux_idx   = w_accept ? bus.req_index : idx_q;
    assign w_req_total = (bus.req_count == '0) ? {1'b1, {IDX_W{1'b0}}}
                                               : bus.req_count;

    slice_mux #(
        .VEC_W   (VEC_W),
        .SLICE_W (SLICE_W),
        .IDX_W   (IDX_W),
        .OFFSET  (OFFSET)
    ) u_mux (
        .store_i (store_q),
        .index_i (w_mux_idx),
        .slice_o (w_slice)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = BURST;
            BURST:   if (out_valid_q && bus.out_ready && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state
    always_comb begin
        store_d     = store_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        load_err_d  = bus.load && !w_idle_free;

        if (bus.load && w_idle_free) begin
            store_d = bus.vec_in;
        end

        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_slice;
            out_index_d = bus.req_index;
            out_last_d  = (w_req_total == (IDX_W+1)'(1));
            idx_d       = bus.req_index + 1'b1;
            rem_d       = w_req_total - 1'b1;
        end else if ((state_q == BURST) && w_advance) begin
            if (rem_q != '0) begin
                out_valid_d = 1'b1;
                out_data_d  = w_slice;
                out_index_d = idx_q;
                out_last_d  = (rem_q == (IDX_W+1)'(1));
                idx_d       = idx_q + 1'b1;
                rem_d       = rem_q - 1'b1;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_slice_extract.sv
`default_nettype none
// ============================================================================
// Module      : tb_slice_extract
// Description : Scoreboard bench for slice_extract. Two instances share the
//               same inputs: one with OFFSET 0, one with an offset that makes
//               slices wrap past the top of the vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_extract;
    localparam int VEC_W   = 1536;
    localparam int SLICE_W = 24;
    localparam int IDX_W   = 6;
    localparam int NSL     = 1 << IDX_W;
    localparam int OFF2    = VEC_W - 5;

    typedef struct {
        logic [SLICE_W-1:0] d0;
        logic [SLICE_W-1:0] d1;
        logic [IDX_W-1:0]   idx;
        logic               last;
    } exp_t;

    logic clk;
    logic rst_n;

    slice_extract_if #(.VEC_W(VEC_W), .SLICE_W(SLICE_W), .IDX_W(IDX_W)) bus ();
    slice_extract_if #(.VEC_W(VEC_W), .SLICE_W(SLICE_W), .IDX_W(IDX_W)) bus2 ();

    assign bus2.load      = bus.load;
    assign bus2.vec_in    = bus.vec_in;
    assign bus2.req_valid = bus.req_valid;
    assign bus2.req_index = bus.req_index;
    assign bus2.req_count = bus.req_count;
    assign bus2.out_ready = bus.out_ready;

    slice_extract #(.VEC_W(VEC_W), .SLICE_W(SLICE_W), .IDX_W(IDX_W), .OFFSET(0))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    slice_extract #(.VEC_W(VEC_W), .SLICE_W(SLICE_W), .IDX_W(IDX_W), .OFFSET(OFF2))
        dut_off (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    exp_t             sb[$];
    logic [VEC_W-1:0] m_store;
    int               ready_mode = 0;
    int               stall_ctr  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Reference: bit i of slice = store[(idx*SLICE_W + off + i) mod VEC_W]
    function automatic logic [SLICE_W-1:0] model_slice(input logic [VEC_W-1:0] st,
                                                       input int idx, input int off);
        logic [SLICE_W-1:0] r;
        for (int i = 0; i < SLICE_W; i++) r[i] = st[(idx * SLICE_W + off + i) % VEC_W];
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int w = 0; w < VEC_W / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    // Downstream ready: 0 = always ready, 1 = random, 2 = three-cycle stall
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                stall_ctr++;
                bus.out_ready = !(stall_ctr >= 3 && stall_ctr <= 5);
            end
        endcase
    end

    // Monitor: pops one expected slice per accepted output, checks holds
    logic               hold_pend = 1'b0;
    logic [SLICE_W-1:0] hold_data;
    logic [IDX_W-1:0]   hold_idx;
    logic               hold_last;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_data",  bus.out_data,  hold_data);
                chk("hold_index", bus.out_index, hold_idx);
                chk("hold_last",  bus.out_last,  hold_last);
            end
            hold_pend = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_slice");
                end else begin
                    e = sb.pop_front();
                    chk("slice_data",     bus.out_data,   e.d0);
                    chk("slice_data_off", bus2.out_data,  e.d1);
                    chk("slice_index",    bus.out_index,  e.idx);
                    chk("slice_last",     bus.out_last,   e.last);
                    chk("off_last",       bus2.out_last,  e.last);
                end
            end else if (bus.out_valid) begin
                hold_pend = 1'b1;
                hold_data = bus.out_data;
                hold_idx  = bus.out_index;
                hold_last = bus.out_last;
            end
        end
    end

    task automatic do_burst(input int i0, input int cnt);
        int  n;
        bit  ok;
        exp_t e;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_index = IDX_W'(i0);
        bus.req_count = (IDX_W+1)'(cnt);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            fail_now("req_accept");
            bus.req_valid = 1'b0;
            return;
        end
        n = (cnt == 0) ? NSL : cnt;
        for (int k = 0; k < n; k++) begin
            e.idx  = IDX_W'((i0 + k) % NSL);
            e.d0   = model_slice(m_store, (i0 + k) % NSL, 0);
            e.d1   = model_slice(m_store, (i0 + k) % NSL, OFF2);
            e.last = (k == n - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", bus.out_valid, 1'b1);
        chk("busy_req_ready", bus.req_ready, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (sb.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
            if (ready_mode == 0 && rst_n && sb.size() != 0 && !bus.out_valid)
                fail_now("bubble");
            @(negedge clk);
        end
        if (!ok) fail_now("burst_done");
    endtask

    task automatic do_load(input logic [VEC_W-1:0] v, input bit expect_ok);
        @(posedge clk); #1;
        bus.load   = 1'b1;
        bus.vec_in = v;
        @(posedge clk);
        if (expect_ok) m_store = v;
        #1 bus.load = 1'b0;
        @(negedge clk);
        chk("load_err", bus.load_err, expect_ok ? 1'b0 : 1'b1);
        @(negedge clk);
        chk("load_err_end", bus.load_err, 1'b0);
    endtask

    initial begin
        logic [VEC_W-1:0] v;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VEC_W-1:0] v;
        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.vec_in    = '0;
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.req_count = '0;
        bus.out_ready = 1'b1;
        m_store       = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last",  bus.out_last,  1'b0);
        chk("rst_out_data",  bus.out_data,  '0);
        chk("rst_out_index", bus.out_index, '0);
        chk("rst_load_err",  bus.load_err,  1'b0);
        chk("rst_req_ready", bus.req_ready, 1'b1);

        // Store cleared by reset
        do_burst(9, 2);

        // Alternating bits, single slice -> 0xAAAAAA
        for (int k = 0; k < VEC_W; k++) v[k] = k[0];
        do_load(v, 1'b1);
        do_burst(0, 1);

        // Slice j holds j; wrap 62,63,0,1
        for (int j = 0; j < NSL; j++) v[j*SLICE_W +: SLICE_W] = SLICE_W'(j);
        do_load(v, 1'b1);
        do_burst(62, 4);

        // Full 64-slice burst starting at 5
        do_burst(5, 0);

        // Three-cycle downstream stall
        stall_ctr  = 0;
        ready_mode = 2;
        do_burst(10, 8);

        // Load during a burst is rejected
        stall_ctr = 0;
        fork
            do_burst(20, 8);
            begin
                repeat (4) @(posedge clk);
                do_load(rand_vec(), 1'b0);
            end
        join
        ready_mode = 0;
        do_burst(20, 3);

        // Load and request together: load wins, request waits
        v = rand_vec();
        @(posedge clk); #1;
        bus.load      = 1'b1;
        bus.vec_in    = v;
        bus.req_valid = 1'b1;
        bus.req_index = 6'd3;
        bus.req_count = 7'd2;
        @(negedge clk);
        chk("req_ready_with_load", bus.req_ready, 1'b0);
        @(posedge clk);
        m_store = v;
        #1;
        bus.load      = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("no_accept_with_load", bus.out_valid, 1'b0);
        do_burst(3, 2);

        // Reset in the middle of a burst
        fork
            do_burst(7, 0);
            begin
                repeat (10) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_valid", bus.out_valid, 1'b0);
                chk("midrst_last",  bus.out_last,  1'b0);
                chk("midrst_data",  bus.out_data,  '0);
                chk("midrst_index", bus.out_index, '0);
                sb.delete();
                m_store = '0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("post_rst_idle_valid", bus.out_valid, 1'b0);
            chk("post_rst_req_ready",  bus.req_ready, 1'b1);
        end
        do_burst(0, 2);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            ready_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) do_load(rand_vec(), 1'b1);
            do_burst($urandom_range(0, NSL - 1), $urandom_range(0, NSL));
        end

        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
